// File: rtl/mul_seq_pkg.sv
// mul_seq_pkg
// Shared types and helpers for the streaming multiplier-sequence generator.
//   state_e      : FSM states (IDLE waits for a request, RUN emits beats)
//   clamp_len    : maps a requested length onto 1..seq_len (0 or too large -> seq_len)
//   lane_keep    : keep-mask helper, one bit per lane of a beat
//   beat_is_last : true when a beat holds the final element of the burst
package mul_seq_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  function automatic int clamp_len(input int cnt, input int seq_len);
    return ((cnt == 0) || (cnt > seq_len)) ? seq_len : cnt;
  endfunction

  // Element index of lane 'lane' in beat 'beat' is beat*lanes + lane (0-based).
  function automatic logic lane_keep(input int beat, input int lane,
                                     input int lanes, input int n);
    return ((beat * lanes) + lane) < n;
  endfunction

  function automatic logic beat_is_last(input int beat, input int lanes,
                                        input int n);
    return ((beat + 1) * lanes) >= n;
  endfunction

endpackage

// File: rtl/mul_seq_lanes.sv
// mul_seq_lanes
// Combinational per-lane offsets X*1 .. X*LANES without a multiplier.
//   x        : operand, already sign/zero-extended to DATA_W
//   lane_off : lane j carries X*(j+1), modulo 2^DATA_W
module mul_seq_lanes
  import mul_seq_pkg::*;
#(
  parameter int DATA_W = 14,
  parameter int LANES  = 4
) (
  input  logic [DATA_W-1:0]             x,
  output logic [LANES-1:0][DATA_W-1:0]  lane_off
);

  // Multiples that are powers of two come straight from a shift; every other
  // lane reuses its neighbour and adds one more X, so the adder chain is
  // never longer than the gap between consecutive powers of two.
  for (genvar j = 0; j < LANES; j++) begin : g_lane
    logic [DATA_W-1:0] val;
    if (((j + 1) & j) == 0) begin : g_pow2
      assign val = x << $clog2(j + 1);
    end else begin : g_inc
      assign val = g_lane[j-1].val + x;
    end
    assign lane_off[j] = val;
  end

endmodule

// File: rtl/mul_seq_stream.sv
// mul_seq_stream
// Accepts operand X and length N, then streams X*1 .. X*N as LANES-wide beats.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   InValid/InReady : request handshake carrying DataIn (X) and SeqCnt (N)
//   OutValid/OutReady : beat handshake
//   DataOut         : LANES elements, lane j = X*(OutBeat*LANES + j + 1)
//   OutKeep         : per-lane valid mask, dropped lanes drive zero
//   OutLast         : final beat of the burst
//   OutBeat         : beat index within the burst
module mul_seq_stream
  import mul_seq_pkg::*;
#(
  parameter int  DATA_IN_W  = 8,
  parameter int  SEQ_LEN    = 32,
  parameter int  LANES      = 4,
  parameter bit  SIGNED     = 1'b0,
  parameter int  CNT_W      = $clog2(SEQ_LEN + 1),
  parameter int  DATA_OUT_W = DATA_IN_W + $clog2(SEQ_LEN + 1),
  localparam int BEAT_W     = ((SEQ_LEN / LANES) > 1) ? $clog2(SEQ_LEN / LANES) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          InValid,
  output logic                          InReady,
  input  logic [DATA_IN_W-1:0]          DataIn,
  input  logic [CNT_W-1:0]              SeqCnt,
  output logic                          OutValid,
  input  logic                          OutReady,
  output logic [LANES*DATA_OUT_W-1:0]   DataOut,
  output logic [LANES-1:0]              OutKeep,
  output logic                          OutLast,
  output logic [BEAT_W-1:0]             OutBeat
);

  localparam int EXT_W = DATA_OUT_W - DATA_IN_W;

  state_e                              state_q, state_d;
  logic [DATA_OUT_W-1:0]               acc_q, acc_d;
  logic [BEAT_W-1:0]                   beat_q, beat_d;
  logic [CNT_W-1:0]                    n_q, n_d;
  logic [LANES-1:0][DATA_OUT_W-1:0]    off_q, off_d;
  logic [LANES-1:0][DATA_OUT_W-1:0]    lane_prod;
  logic [DATA_OUT_W-1:0]               x_ext;
  logic                                last_beat;
  logic                                accept;

  assign x_ext = SIGNED ? {{EXT_W{DataIn[DATA_IN_W-1]}}, DataIn}
                        : {{EXT_W{1'b0}}, DataIn};

  mul_seq_lanes #(
    .DATA_W (DATA_OUT_W),
    .LANES  (LANES)
  ) u_lanes (
    .x        (x_ext),
    .lane_off (lane_prod)
  );

  assign last_beat = beat_is_last(int'(beat_q), LANES, int'(n_q));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      beat_q  <= '0;
      n_q     <= '0;
      off_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      beat_q  <= beat_d;
      n_q     <= n_d;
      off_q   <= off_d;
    end
  end

  // Outputs are decoded purely from registered state, so a stalled beat stays
  // stable. A request accepted on the last-beat handshake overrides the
  // return to IDLE and reloads everything, so the next burst follows with no
  // bubble.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    beat_d   = beat_q;
    n_d      = n_q;
    off_d    = off_q;
    InReady  = 1'b0;
    OutValid = 1'b0;
    OutLast  = 1'b0;
    OutKeep  = '0;
    OutBeat  = '0;
    DataOut  = '0;
    accept   = 1'b0;

    case (state_q)
      IDLE: begin
        InReady = 1'b1;
      end
      RUN: begin
        OutValid = 1'b1;
        OutLast  = last_beat;
        OutBeat  = beat_q;
        for (int j = 0; j < LANES; j++) begin
          OutKeep[j] = lane_keep(int'(beat_q), j, LANES, int'(n_q));
          if (OutKeep[j]) begin
            DataOut[j*DATA_OUT_W +: DATA_OUT_W] = acc_q + off_q[j];
          end
        end
        if (OutReady) begin
          if (last_beat) begin
            InReady = 1'b1;
            state_d = IDLE;
          end else begin
            // The top lane is X*LANES, exactly the stride between beats.
            acc_d  = acc_q + off_q[LANES-1];
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    accept = InValid && InReady;
    if (accept) begin
      state_d = RUN;
      acc_d   = '0;
      beat_d  = '0;
      n_d     = CNT_W'(clamp_len(int'(SeqCnt), SEQ_LEN));
      off_d   = lane_prod;
    end
  end

endmodule

// File: doc/mul_seq_stream.md
# mul_seq_stream

Streaming multiplier-sequence generator. Accepts one operand X and a length N over a valid/ready handshake, then emits X·1, X·2, …, X·N as a burst of LANES-wide beats. No multipliers are used: a running accumulator advances by X·LANES per beat, and per-lane offsets X·1..X·LANES are built once per request by shift-and-add sharing. It sits between address/stride generators and downstream consumers that need scaled-index sequences longer than a single combinational array can provide.

## Interface
Parameters:
- DATA_IN_W, 8, operand width.
- SEQ_LEN, 32, maximum sequence length; must be a multiple of LANES.
- LANES, 4, elements per output beat; power of 2, 1 ≤ LANES ≤ SEQ_LEN.
- SIGNED, 0, 1 = operand is two's complement and outputs are sign-extended.
- CNT_W, $clog2(SEQ_LEN+1), length field width.
- DATA_OUT_W, DATA_IN_W + $clog2(SEQ_LEN+1), element width; holds X·SEQ_LEN exactly.

Ports (one clock `clk`; reset `rst` is synchronous, active-high):
- clk, in, 1, clock.
- rst, in, 1, synchronous active-high reset.
- InValid, in, 1, request valid.
- InReady, out, 1, request ready.
- DataIn, in, DATA_IN_W, operand X.
- SeqCnt, in, CNT_W, N; 0 or any value > SEQ_LEN is treated as SEQ_LEN.
- OutValid, out, 1, beat valid.
- OutReady, in, 1, beat ready.
- DataOut, out, LANES × DATA_OUT_W, lane j = X·(BeatIdx·LANES + j + 1).
- OutKeep, out, LANES, lane j valid: BeatIdx·LANES + j < N.
- OutLast, out, 1, final beat of the burst.
- OutBeat, out, $clog2(SEQ_LEN/LANES) (min 1), beat index within the burst.

## Operation
- FSM states: IDLE and RUN.
- IDLE:
  - InReady = 1.
  - On InValid && InReady: latch X (sign-extended or zero-extended to DATA_OUT_W), latch N (clamped), set Acc = 0, BeatIdx = 0, compute LaneOff[j] = X·(j+1), and go to RUN.
- RUN:
  - OutValid = 1.
  - DataOut[j] = Acc + LaneOff[j].
  - OutKeep and OutLast are decoded from BeatIdx and N.
  - On OutReady, non-last beat: Acc += LaneOff[LANES-1]; BeatIdx++.
  - On OutReady, last beat: return to IDLE, unless a new request is accepted in the same cycle.
- Back-to-back bursts: InReady = IDLE | (RUN & OutLast & OutReady). A request accepted on the last-beat handshake reloads all state and stays in RUN, giving no bubble.
- Backpressure: while OutValid && !OutReady, DataOut, OutKeep, OutLast and OutBeat hold stable.
- Lanes with OutKeep = 0 drive 0.
- Arithmetic:
  - All sums are taken modulo 2^DATA_OUT_W. No overflow occurs by construction.
  - SIGNED = 1 yields exact two's-complement products.
- Edge cases:
  - X = 0 gives an all-zero burst of normal length.
  - N = 1 gives a single beat with only lane 0 kept, and OutLast = 1.

## Timing
- Reset values: state IDLE, InReady 1 (combinational from IDLE), OutValid 0, OutLast 0, OutKeep 0, DataOut 0, OutBeat 0, Acc 0.
- Latency: first beat OutValid is asserted in the cycle after the accepting edge.
- Throughput: one beat per cycle when OutReady = 1.
- Burst length: ceil(N/LANES) beats.
- Reset mid-burst: the burst is abandoned and the block is in IDLE on the next cycle. No partial beats follow.
- InReady is combinational from OutReady only in RUN. There is no combinational path from InValid to OutValid.

## Structure
- Package mul_seq_pkg holds:
  - the state enum typedef (IDLE, RUN);
  - the clamp helper function for N;
  - the keep-mask helper function.
- Sub-module mul_seq_lanes: combinational X·1..X·LANES.
  - Powers of 2 are built by shift.
  - Every other lane equals the previous lane + X.
  - Its outputs are registered into LaneOff at accept.
- Top level contains the FSM, Acc, BeatIdx, handshake logic and output decode.

## Test plan
- Basic burst: SIGNED=0, LANES=4, X=5, N=8, OutReady=1 → two beats, {5,10,15,20} then {25,30,35,40}; Keep 1111/1111; OutLast on beat 1.
- Partial last beat: X=3, N=6 → {3,6,9,12} then {15,18,0,0} with Keep 0011 and OutLast=1.
- Clamp and maximum: X=255, N=0 → 8 beats; final lane = 8160; no truncation in the 14-bit output.
- Signed: SIGNED=1, X=-2 (8'hFE), N=4 → {-2,-4,-6,-8} sign-extended.
- Backpressure and back-to-back:
  - Hold OutReady low for 3 cycles mid-burst → outputs stable throughout.
  - Present the next request during the last-beat handshake → InReady=1 that cycle; next beat is the new burst's beat 0 with no bubble.
- Reset mid-burst: assert rst during beat 1 of 8 → next cycle OutValid=0, InReady=1; a fresh request restarts at X·1.
